// File: rtl/noc_params.sv
// Shared flit, port and input-buffer state types for the chiplet router.
package noc_params;

  localparam int unsigned DEST_X_W  = 4;
  localparam int unsigned DEST_Y_W  = 4;
  localparam int unsigned PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_type_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTING = 2'd1,
    ACTIVE  = 2'd2
  } ib_state_t;

  typedef struct packed {
    flit_type_t             flit_type;
    logic [DEST_X_W-1:0]    x_dest;
    logic [DEST_Y_W-1:0]    y_dest;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  function automatic logic is_head_type(input flit_type_t t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

  function automatic logic is_tail_type(input flit_type_t t);
    return (t == TAIL) || (t == HEADTAIL);
  endfunction

endpackage

// File: rtl/chiplet_circular_buffer.sv
// Circular flit FIFO: wrapping pointers, occupancy counter, full/empty flags.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module chiplet_circular_buffer
  import noc_params::*;
#(
  parameter int unsigned BUFFER_DEPTH = 8
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  flit_t data_i,
  input  logic  write_i,
  input  logic  read_i,
  output flit_t data_o,
  output logic  is_empty_o,
  output logic  is_full_o
);

  localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);

  flit_t            r_mem [BUFFER_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign is_empty_o = (r_count == '0);
  assign is_full_o  = (r_count == (PTR_W+1)'(BUFFER_DEPTH));
  assign w_pop      = read_i && !is_empty_o;
  assign w_push     = write_i && (!is_full_o || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // Gate the head so stale storage never leaks out while empty.
  assign data_o = is_empty_o ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/chiplet_input_buffer.sv
// Router input port: flit FIFO plus per-packet routing FSM, error and credit logic.
// Define CHIPLET_IB_CREDIT_EN to build the registered credit-return pulse.
module chiplet_input_buffer
  import noc_params::*;
#(
  parameter int unsigned BUFFER_DEPTH     = 8,
  parameter int unsigned DEST_ADDR_SIZE_X = 4,
  parameter int unsigned DEST_ADDR_SIZE_Y = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  flit_t                       flit_i,
  input  logic                        valid_flit_i,
  output logic [DEST_ADDR_SIZE_X-1:0] x_dest_o,
  output logic [DEST_ADDR_SIZE_Y-1:0] y_dest_o,
  input  port_t                       out_port_i,
  output port_t                       out_port_o,
  output logic                        route_valid_o,
  input  logic                        read_i,
  output flit_t                       flit_o,
  output logic                        is_empty_o,
  output logic                        is_full_o,
  output logic                        credit_o,
  output logic                        error_o
);

  ib_state_t r_state;
  ib_state_t w_state_next;
  port_t     r_out_port;
  logic      r_first;
  logic      r_error;
  flit_t     w_head;
  logic      w_is_empty;
  logic      w_is_full;
  logic      w_pop;
  logic      w_discard;
  logic      w_latch;
  logic      w_route_valid;
  logic      w_overflow;
  logic      w_stray_head;

  chiplet_circular_buffer #(
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) u_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_i     (flit_i),
    .write_i    (valid_flit_i),
    .read_i     (w_pop),
    .data_o     (w_head),
    .is_empty_o (w_is_empty),
    .is_full_o  (w_is_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_is_empty && is_head_type(w_head.flit_type)) w_state_next = ROUTING;
      ROUTING: w_state_next = ACTIVE;
      ACTIVE:  if (w_pop && is_tail_type(w_head.flit_type)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_pop         = 1'b0;
    w_discard     = 1'b0;
    w_latch       = 1'b0;
    w_route_valid = 1'b0;
    case (r_state)
      IDLE: begin
        // A headless BODY/TAIL can never be routed, so drop it here.
        if (!w_is_empty && !is_head_type(w_head.flit_type)) begin
          w_pop     = 1'b1;
          w_discard = 1'b1;
        end
      end
      ROUTING: w_latch = 1'b1;
      ACTIVE: begin
        w_route_valid = !w_is_empty;
        w_pop         = read_i && !w_is_empty;
      end
      default: ;
    endcase
  end

  // r_first marks that the packet's own head is still at the FIFO head.
  assign w_stray_head = (r_state == ACTIVE) && !w_is_empty && !r_first
                        && is_head_type(w_head.flit_type);
  assign w_overflow   = valid_flit_i && w_is_full && !w_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_port <= LOCAL;
      r_first    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_latch) r_out_port <= out_port_i;
      if (w_latch)    r_first <= 1'b1;
      else if (w_pop) r_first <= 1'b0;
      if (w_overflow || w_discard || w_stray_head) r_error <= 1'b1;
    end
  end

`ifdef CHIPLET_IB_CREDIT_EN
  logic r_credit;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_credit <= 1'b0;
    else         r_credit <= w_pop;
  end
  assign credit_o = r_credit;
`else
  assign credit_o = 1'b0;
`endif

  assign x_dest_o      = DEST_ADDR_SIZE_X'(w_head.x_dest);
  assign y_dest_o      = DEST_ADDR_SIZE_Y'(w_head.y_dest);
  assign out_port_o    = r_out_port;
  assign route_valid_o = w_route_valid;
  assign flit_o        = w_head;
  assign is_empty_o    = w_is_empty;
  assign is_full_o     = w_is_full;
  assign error_o       = r_error;

endmodule

// File: tb/tb_chiplet_input_buffer.sv
// Scoreboard bench for chiplet_input_buffer: expected pops queued at push time,
// checked by a negedge monitor on every route_valid_o && read_i handshake.
module tb_chiplet_input_buffer;
  import noc_params::*;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  flit_t      flit_i = '0;
  logic       valid_flit_i = 1'b0;
  logic [3:0] x_dest_o;
  logic [3:0] y_dest_o;
  port_t      out_port_i = LOCAL;
  port_t      out_port_o;
  logic       route_valid_o;
  logic       read_i = 1'b0;
  flit_t      flit_o;
  logic       is_empty_o;
  logic       is_full_o;
  logic       credit_o;
  logic       error_o;

`ifdef CHIPLET_IB_CREDIT_EN
  localparam logic CREDIT_ON = 1'b1;
`else
  localparam logic CREDIT_ON = 1'b0;
`endif

  chiplet_input_buffer #(
    .BUFFER_DEPTH     (8),
    .DEST_ADDR_SIZE_X (4),
    .DEST_ADDR_SIZE_Y (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flit_i        (flit_i),
    .valid_flit_i  (valid_flit_i),
    .x_dest_o      (x_dest_o),
    .y_dest_o      (y_dest_o),
    .out_port_i    (out_port_i),
    .out_port_o    (out_port_o),
    .route_valid_o (route_valid_o),
    .read_i        (read_i),
    .flit_o        (flit_o),
    .is_empty_o    (is_empty_o),
    .is_full_o     (is_full_o),
    .credit_o      (credit_o),
    .error_o       (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    flit_t flit;
    port_t port;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(input flit_type_t t, input logic [3:0] x,
                               input logic [3:0] y, input logic [15:0] p);
    flit_t f;
    f.flit_type = t;
    f.x_dest    = x;
    f.y_dest    = y;
    f.payload   = p;
    return f;
  endfunction

  always @(negedge clk_i) begin
    if (rst_ni && route_valid_o && read_i) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got flit %0h expected no pop", flit_o);
      end else begin
        mon_e = sb_q.pop_front();
        check("pop_flit", flit_o, mon_e.flit);
        check("pop_port", out_port_o, mon_e.port);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push(input flit_t f, input port_t p, input logic expect_pop);
    flit_i       = f;
    valid_flit_i = 1'b1;
    if (expect_pop) sb_q.push_back('{flit: f, port: p});
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    step();
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    valid_flit_i = 1'b0;
    read_i       = 1'b0;
    flit_i       = '0;
    out_port_i   = LOCAL;
    sb_q.delete();
    release_reset();
  endtask

  // Single-flit packet: pushed in cycle 0, routed by cycle 3, popped in cycle 3.
  task automatic run_headtail(input port_t p, input logic [3:0] x, input logic [3:0] y,
                              input logic [15:0] pay);
    out_port_i = p;
    push(mk(HEADTAIL, x, y, pay), p, 1'b1);
    step();
    valid_flit_i = 1'b0;
    check("ht_x_dest_c1", x_dest_o, x);
    check("ht_y_dest_c1", y_dest_o, y);
    check("ht_rv_c1", route_valid_o, 1'b0);
    step();
    check("ht_rv_c2", route_valid_o, 1'b0);
    step();
    check("ht_rv_c3", route_valid_o, 1'b1);
    check("ht_port_c3", out_port_o, p);
    read_i = 1'b1;
    step();
    read_i = 1'b0;
    check("ht_state_c4", dut.r_state, IDLE);
    check("ht_empty_c4", is_empty_o, 1'b1);
    check("ht_credit_c4", credit_o, CREDIT_ON);
    step();
    check("ht_credit_c5", credit_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    do_reset();
    check("rst_route_valid", route_valid_o, 1'b0);
    check("rst_empty", is_empty_o, 1'b1);
    check("rst_full", is_full_o, 1'b0);
    check("rst_error", error_o, 1'b0);
    check("rst_port", out_port_o, LOCAL);
    check("rst_credit", credit_o, 1'b0);
    check("rst_flit", flit_o, 26'h0);

    // Single HEADTAIL to EAST
    run_headtail(EAST, 4'd3, 4'd1, 16'hA5A5);

    // Four-flit packet with read_i held high; route changes after latch
    do_reset();
    out_port_i = SOUTH;
    read_i     = 1'b1;
    push(mk(HEAD, 4'd2, 4'd2, 16'h0001), SOUTH, 1'b1); step();
    push(mk(BODY, 4'd0, 4'd0, 16'h0002), SOUTH, 1'b1); step();
    push(mk(BODY, 4'd0, 4'd0, 16'h0003), SOUTH, 1'b1); step();
    check("pkt_rv_c3", route_valid_o, 1'b1);
    push(mk(TAIL, 4'd0, 4'd0, 16'h0004), SOUTH, 1'b1); step();
    valid_flit_i = 1'b0;
    out_port_i   = NORTH;
    step(); step();
    check("pkt_rv_c6", route_valid_o, 1'b1);
    step();
    check("pkt_state_c7", dut.r_state, IDLE);
    check("pkt_empty_c7", is_empty_o, 1'b1);
    check("pkt_sb_drained", sb_q.size(), 0);
    check("pkt_error", error_o, 1'b0);
    read_i = 1'b0;

    // Fill, full push+pop, overflow drop, then drain
    do_reset();
    out_port_i = WEST;
    push(mk(HEAD, 4'd1, 4'd7, 16'h1000), WEST, 1'b1); step();
    for (int i = 1; i < 8; i++) begin
      push(mk(BODY, 4'd0, 4'd0, 16'(16'h1000 + i)), WEST, 1'b1);
      step();
    end
    check("fill_full_c8", is_full_o, 1'b1);
    check("fill_error_c8", error_o, 1'b0);
    check("fill_rv_c8", route_valid_o, 1'b1);
    push(mk(TAIL, 4'd0, 4'd0, 16'h1008), WEST, 1'b1);
    read_i = 1'b1;
    step();
    read_i = 1'b0;
    check("pushpop_full_c9", is_full_o, 1'b1);
    check("pushpop_error_c9", error_o, 1'b0);
    push(mk(BODY, 4'd0, 4'd0, 16'hDEAD), WEST, 1'b0);
    step();
    valid_flit_i = 1'b0;
    check("ovf_error_c10", error_o, 1'b1);
    check("ovf_full_c10", is_full_o, 1'b1);
    read_i = 1'b1;
    repeat (8) step();
    read_i = 1'b0;
    check("drain_empty", is_empty_o, 1'b1);
    check("drain_state", dut.r_state, IDLE);
    check("drain_sb", sb_q.size(), 0);

    // Headless BODY is discarded in IDLE
    do_reset();
    push(mk(BODY, 4'd5, 4'd5, 16'hBEEF), LOCAL, 1'b0);
    step();
    valid_flit_i = 1'b0;
    check("body_empty_c1", is_empty_o, 1'b0);
    check("body_error_c1", error_o, 1'b0);
    step();
    check("body_error_c2", error_o, 1'b1);
    check("body_empty_c2", is_empty_o, 1'b1);
    check("body_credit_c2", credit_o, CREDIT_ON);
    check("body_state_c2", dut.r_state, IDLE);

    // Asynchronous reset mid-packet with 5 flits buffered
    do_reset();
    out_port_i = EAST;
    push(mk(HEAD, 4'd4, 4'd4, 16'h2000), EAST, 1'b1); step();
    for (int i = 1; i < 5; i++) begin
      push(mk(BODY, 4'd0, 4'd0, 16'(16'h2000 + i)), EAST, 1'b1);
      step();
    end
    valid_flit_i = 1'b0;
    check("mid_rv_pre", route_valid_o, 1'b1);
    check("mid_port_pre", out_port_o, EAST);
    #2 rst_ni = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rv_async", route_valid_o, 1'b0);
    check("mid_empty_async", is_empty_o, 1'b1);
    check("mid_port_async", out_port_o, LOCAL);
    check("mid_flit_async", flit_o, 26'h0);
    check("mid_state_async", dut.r_state, IDLE);
    release_reset();
    run_headtail(NORTH, 4'd6, 4'd2, 16'h5A5A);

    check("final_sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
